// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: shares one single-ported memory between
// an instruction-fetch read port and a data read/write port.
module mem_port_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] win_q, win_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              busy_q, busy_d;

  logic if_v, d_v, pick_d;

  // In ACK the port being acknowledged may still hold its request.
  assign if_v   = if_req && !(state_q == ACK && grant_q == FETCH);
  assign d_v    = d_req  && !(state_q == ACK && grant_q == DATA);
  assign pick_d = d_v && (!if_v || last_q == FETCH);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    win_d     = win_q;
    if_ack_d  = 1'b0;
    d_ack_d   = 1'b0;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE, ACK: begin
        if (if_v || d_v) begin
          state_d = ACCESS;
          busy_d  = 1'b1;
          grant_d = pick_d;
          last_d  = pick_d;
          addr_d  = pick_d ? d_addr : if_addr;
          if (pick_d && d_we) begin
            wr_d  = 1'b1;
            win_d = d_wdata;
          end else begin
            rd_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      ACCESS: begin
        state_d = ACK;
        busy_d  = 1'b1;
        if (rd_q) begin
          if (grant_q == DATA) d_rdata_d = mem_out;
          else                 if_data_d = mem_out;
        end
        d_ack_d  = (grant_q == DATA);
        if_ack_d = (grant_q == FETCH);
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= FETCH;
      last_q    <= FETCH;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      win_q     <= '0;
      if_ack_q  <= 1'b0;
      d_ack_q   <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      win_q     <= win_d;
      if_ack_q  <= if_ack_d;
      d_ack_q   <= d_ack_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
      busy_q    <= busy_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_rd      = rd_q;
  assign mem_wr      = wr_q;
  assign mem_in      = win_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
  assign if_data     = if_data_q;
  assign d_rdata     = d_rdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: vector table, corner sequences and
// randomized two-requester traffic against a memory/ordering model.
module tb_mem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_data;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_address;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;
  logic          busy;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_address(mem_address), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_in(mem_in),
    .mem_out(mem_out), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [32];
  logic          mem_init;

  assign mem_out = mem[mem_address];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= DW'(i);
      mem[21] <= 16'hF400;
      mem[22] <= 16'hF420;
    end else if (mem_wr) begin
      mem[mem_address] <= mem_in;
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    mem_init = 1'b1;
    idle_inputs();
    step();
    step();
    mem_init = 1'b0;
    reset    = 1'b0;
    step();
  endtask

  typedef struct {
    logic          isd;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t          tbl [8];
  logic [DW-1:0] model [32];
  logic          act [2];
  logic [AW-1:0] raddr [2];
  logic          rwe;
  logic [DW-1:0] rwd;
  int            exp_in [2];
  int            waitc [2];
  logic          prev_strobe;
  byte           seq [$];
  int            n_rd, got;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 1'b0, 5'd21, 16'h0000, 16'hF400};
    tbl[1] = '{1'b1, 1'b1, 5'd3,  16'h00AA, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 5'd3,  16'h0000, 16'h00AA};
    tbl[3] = '{1'b0, 1'b0, 5'd22, 16'h0000, 16'hF420};
    tbl[4] = '{1'b1, 1'b1, 5'd31, 16'hBEEF, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 5'd31, 16'h0000, 16'hBEEF};
    tbl[6] = '{1'b1, 1'b0, 5'd5,  16'h0000, 16'h0005};
    tbl[7] = '{1'b0, 1'b0, 5'd0,  16'h0000, 16'h0000};

    // reset values while reset is held
    reset    = 1'b1;
    mem_init = 1'b1;
    idle_inputs();
    step();
    step();
    chk("rst_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("rst_acks", 32'({if_ack, d_ack}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr", 32'(mem_address), 0);
    chk("rst_mem_in", 32'(mem_in), 0);
    chk("rst_if_data", 32'(if_data), 0);
    chk("rst_d_rdata", 32'(d_rdata), 0);
    mem_init = 1'b0;
    reset    = 1'b0;
    step();

    // single transactions from IDLE
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].isd) begin
        d_req   = 1'b1;
        d_we    = tbl[i].we;
        d_addr  = tbl[i].addr;
        d_wdata = tbl[i].wd;
      end else begin
        if_req  = 1'b1;
        if_addr = tbl[i].addr;
      end
      step();
      chk("vec_strobe", 32'({mem_rd, mem_wr}),
          tbl[i].we ? 32'h1 : 32'h2);
      chk("vec_addr", 32'(mem_address), 32'(tbl[i].addr));
      chk("vec_busy", 32'(busy), 1);
      if (tbl[i].we) chk("vec_mem_in", 32'(mem_in), 32'(tbl[i].wd));
      step();
      chk("vec_ack", 32'({if_ack, d_ack}),
          tbl[i].isd ? 32'h1 : 32'h2);
      chk("vec_ack_strobe", 32'({mem_rd, mem_wr}), 0);
      if (!tbl[i].we)
        chk("vec_rdata", 32'(tbl[i].isd ? d_rdata : if_data),
            32'(tbl[i].exp));
      idle_inputs();
      step();
    end

    // back-to-back fetches with if_req held
    if_req  = 1'b1;
    if_addr = 5'd21;
    n_rd    = 0;
    got     = 0;
    for (int c = 0; c < 20 && got < 2; c++) begin
      step();
      if (mem_rd) n_rd++;
      if (if_ack) begin
        got++;
        chk("b2b_data", 32'(if_data), got == 1 ? 32'hF400 : 32'hF420);
        if_addr = 5'd22;
      end
    end
    idle_inputs();
    chk("b2b_acks", 32'(got), 2);
    chk("b2b_rd_pulses", 32'(n_rd), 2);
    step();

    // simultaneous requests after reset: data wins first
    do_reset();
    if_req  = 1'b1;
    if_addr = 5'd21;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 5'd5;
    step();
    chk("cf_first_addr", 32'(mem_address), 5);
    chk("cf_first_rd", 32'(mem_rd), 1);
    step();
    chk("cf_d_ack", 32'({if_ack, d_ack}), 1);
    chk("cf_d_rdata", 32'(d_rdata), 5);
    chk("cf_gap1", 32'({mem_rd, mem_wr}), 0);
    d_req = 1'b0;
    step();
    chk("cf_second_addr", 32'(mem_address), 21);
    chk("cf_second_rd", 32'(mem_rd), 1);
    chk("cf_no_ack", 32'({if_ack, d_ack}), 0);
    step();
    chk("cf_if_ack", 32'({if_ack, d_ack}), 2);
    chk("cf_if_data", 32'(if_data), 32'hF400);
    chk("cf_gap2", 32'({mem_rd, mem_wr}), 0);
    idle_inputs();
    step();
    step();

    // both requests held continuously: grants alternate D,F,...
    if_req  = 1'b1;
    if_addr = 5'd22;
    d_req   = 1'b1;
    d_addr  = 5'd5;
    seq.delete();
    for (int c = 0; c < 40 && seq.size() < 8; c++) begin
      step();
      chk("alt_strobes", 32'(mem_rd & mem_wr), 0);
      chk("alt_acks", 32'(if_ack & d_ack), 0);
      if (d_ack) seq.push_back("D");
      if (if_ack) seq.push_back("F");
    end
    chk("alt_count", 32'(seq.size()), 8);
    for (int k = 0; k < seq.size(); k++)
      chk("alt_order", 32'(seq[k]), (k % 2 == 0) ? 32'("D") : 32'("F"));
    idle_inputs();
    step();
    step();

    // reset in the middle of an access
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 5'd0;
    step();
    chk("rm_rd_before", 32'(mem_rd), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm_strobes", 32'({mem_rd, mem_wr}), 0);
    chk("rm_acks", 32'({if_ack, d_ack}), 0);
    chk("rm_busy", 32'(busy), 0);
    idle_inputs();
    step();
    chk("rm_no_ack", 32'({if_ack, d_ack}), 0);
    reset = 1'b0;
    step();
    chk("rm_idle_ack", 32'({if_ack, d_ack}), 0);
    if_req  = 1'b1;
    if_addr = 5'd1;
    step();
    chk("rm_fetch_rd", 32'(mem_rd), 1);
    step();
    chk("rm_fetch_ack", 32'(if_ack), 1);
    chk("rm_fetch_data", 32'(if_data), 1);
    idle_inputs();
    step();

    // randomized traffic against a memory and ordering model
    do_reset();
    for (int i = 0; i < 32; i++) model[i] = DW'(i);
    model[21]   = 16'hF400;
    model[22]   = 16'hF420;
    act[0]      = 1'b0;
    act[1]      = 1'b0;
    exp_in[0]   = 0;
    exp_in[1]   = 0;
    waitc[0]    = 0;
    waitc[1]    = 0;
    rwe         = 1'b0;
    rwd         = '0;
    prev_strobe = 1'b0;
    for (int c = 0; c < 600; c++) begin
      step();
      chk("rnd_one_strobe", 32'(mem_rd & mem_wr), 0);
      chk("rnd_one_ack", 32'(if_ack & d_ack), 0);
      if (prev_strobe) chk("rnd_strobe_gap", 32'(mem_rd | mem_wr), 0);
      prev_strobe = mem_rd | mem_wr;
      for (int p = 0; p < 2; p++) begin
        if (exp_in[p] != 0) begin
          exp_in[p]--;
          if (exp_in[p] == 0)
            chk("rnd_handoff", 32'(p == 0 ? if_ack : d_ack), 1);
        end
      end
      if (if_ack) begin
        chk("rnd_if_ack_req", 32'(act[0]), 1);
        if (act[0]) chk("rnd_if_data", 32'(if_data), 32'(model[raddr[0]]));
        act[0] = 1'b0;
        if_req = 1'b0;
        if (act[1]) exp_in[1] = 2;
      end
      if (d_ack) begin
        chk("rnd_d_ack_req", 32'(act[1]), 1);
        if (act[1] && rwe) model[raddr[1]] = rwd;
        else if (act[1])
          chk("rnd_d_rdata", 32'(d_rdata), 32'(model[raddr[1]]));
        act[1] = 1'b0;
        d_req  = 1'b0;
        if (act[0]) exp_in[0] = 2;
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          waitc[p]++;
          if (waitc[p] > 6) begin
            chk("rnd_ack_timeout", 32'(waitc[p]), 6);
            act[p] = 1'b0;
            if (p == 0) if_req = 1'b0;
            else        d_req  = 1'b0;
          end
        end
      end
      if (!act[0] && $urandom_range(0, 2) == 0) begin
        act[0]   = 1'b1;
        waitc[0] = 0;
        raddr[0] = AW'($urandom_range(0, 7));
        if_addr  = raddr[0];
        if_req   = 1'b1;
      end
      if (!act[1] && $urandom_range(0, 2) == 0) begin
        act[1]   = 1'b1;
        waitc[1] = 0;
        raddr[1] = AW'($urandom_range(0, 7));
        rwe      = 1'($urandom_range(0, 1));
        rwd      = DW'($urandom);
        d_addr   = raddr[1];
        d_we     = rwe;
        d_wdata  = rwd;
        d_req    = 1'b1;
      end
    end
    idle_inputs();
    step();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
